keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 active-low matrix keypad from the board header and delivers one debounced key code per physical press over a valid/ready handshake. It is the input-side counterpart of the seven-segment and LED output path: it drives the keypad columns, samples the rows, filters bounce, and hands a 4-bit code to downstream logic such as the display translator or the arithmetic units.

## Interface
- SETTLE_CYCLES, 64: cycles a column is driven before its rows are sampled; legal minimum 3.
- DEBOUNCE_CYCLES, 500000: consecutive identical samples required to accept a press or a release (10 ms at 50 MHz); legal minimum 1.
- i_CLOCK_POS  input  1  single clock, rising edge.
- i_RESET_POS  input  1  synchronous, active-high reset.
- i_VECTOR_ROW  input  4  keypad rows, active-low, externally pulled up, asynchronous.
- o_VECTOR_COLUMN  output  4  column drive, one-hot-low; bit c low means column c is driven.
- o_VECTOR_KEY  output  4  key code {row[1:0], col[1:0]}.
- o_BIT_VALID  output  1  key code available.
- i_BIT_READY  input  1  consumer accepts the code.
- o_BIT_PRESSED  output  1  an accepted key is still being held.

## Operation
- Rows pass through a 2-flop synchronizer before any use.
- States:
  - SCAN: drive column idx. Wait SETTLE_CYCLES, then sample the rows.
    - No row low: idx advances, wrapping 3 to 0, and the settle counter restarts.
    - Any row low: capture the lowest-index low row and the current column, then go to DEBOUNCE.
  - DEBOUNCE: the same column stays driven. Count consecutive cycles in which the synchronized rows equal the captured pattern.
    - Mismatch: return to SCAN on the same column with the counter cleared.
    - Count reaches DEBOUNCE_CYCLES: go to PRESENT.
  - PRESENT: o_BIT_VALID=1, and o_VECTOR_KEY holds the captured code. Valid and code stay stable until i_BIT_READY=1. The handshake completes in the cycle both are high, then go to RELEASE.
  - RELEASE: the same column stays driven. Count consecutive cycles with all rows high. Any low row clears the count. When the count reaches DEBOUNCE_CYCLES, idx advances and the block returns to SCAN.
- o_BIT_PRESSED is 1 from entry to PRESENT until exit from RELEASE.
- Multiple rows low in one column: the lowest row index wins. Keys in other columns are ignored until RELEASE completes. One press yields exactly one code and there is no auto-repeat.
- A key released while in PRESENT does not cancel valid. The code is delivered and RELEASE then completes normally.
- Reset in any state: the next cycle is SCAN with idx=0 and all counters cleared, and any pending code is discarded.

## Timing
- Reset values:
  - o_VECTOR_COLUMN=4'b1110
  - o_BIT_VALID=0
  - o_VECTOR_KEY=4'h0
  - o_BIT_PRESSED=0
  - synchronizer flops = 4'b1111
- All outputs are registered and there is no combinational path from i_BIT_READY.
- Idle scan: each column is driven for exactly SETTLE_CYCLES cycles, giving a full sweep of 4*SETTLE_CYCLES cycles.
- Press to valid: at most 4*SETTLE_CYCLES + DEBOUNCE_CYCLES + 3 cycles after the row becomes stable. This includes 2 cycles of synchronizer latency.
- o_BIT_VALID rises on the clock edge after the debounce count completes. It falls on the edge after the handshake.
- i_BIT_READY held high continuously: valid lasts exactly one cycle.
- Column change to first sample: exactly SETTLE_CYCLES cycles. The minimum of 3 covers the synchronizer delay.

## Structure
- Shared package keypad_pkg:
  - state enum {SCAN, DEBOUNCE, PRESENT, RELEASE}
  - constants KEY_ROWS=4, KEY_COLS=4, KEY_CODE_WIDTH=4
- Sub-module row_synchronizer: parameterized-width 2-flop synchronizer with reset to all ones. It is reusable for the switch and key inputs.
- Counters are sized as $clog2(max parameter + 1).

## Test plan
Keypad model uses bounce injection. Overrides are SETTLE_CYCLES=4, DEBOUNCE_CYCLES=8.
- Reset, no key pressed: o_VECTOR_COLUMN cycles 1110, 1101, 1011, 0111 with 4 cycles each and wraps. Valid stays 0.
- Row 2 pulled low while column 1 is driven, clean, ready=1: valid pulses 1 cycle with key=4'h9. Pressed=1 until 8 cycles after release.
- The same press with 5 cycles of toggling bounce before it settles: exactly one valid, with key=4'h9. No valid is produced during the bounce.
- Key 4'h3 pressed, ready=0 for 50 cycles, key released at cycle 20: valid and key are held for 50 cycles. Accepted when ready=1. Scanning resumes afterwards.
- Rows 1 and 3 low together in column 0: key=4'h4.
- Reset asserted during DEBOUNCE, then in PRESENT: outputs return to reset values on the next cycle. No code is delivered.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned KEY_ROWS       = 4;
  localparam int unsigned KEY_COLS       = 4;
  localparam int unsigned KEY_CODE_WIDTH = 4;
  localparam int unsigned ROW_IDX_W      = $clog2(KEY_ROWS);
  localparam int unsigned COL_IDX_W      = $clog2(KEY_COLS);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESENT,
    RELEASE
  } keypad_state_e;

  typedef struct packed {
    logic [ROW_IDX_W-1:0] row;
    logic [COL_IDX_W-1:0] col;
  } key_code_t;

  // Index of the lowest active-low row; caller guarantees at least one is low.
  function automatic logic [ROW_IDX_W-1:0] lowest_low_row(input logic [KEY_ROWS-1:0] rows);
    lowest_low_row = '0;
    for (int i = KEY_ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) lowest_low_row = ROW_IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/row_synchronizer.sv
// Parameterized 2-flop synchronizer for asynchronous active-low inputs; resets to all ones.
module row_synchronizer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning 4x4 keypad reader: debounces press and release and hands
// one key code per press downstream over valid/ready.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES   = 64,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                      i_CLOCK_POS,
  input  logic                      i_RESET_POS,
  input  logic [KEY_ROWS-1:0]       i_VECTOR_ROW,
  output logic [KEY_COLS-1:0]       o_VECTOR_COLUMN,
  output logic [KEY_CODE_WIDTH-1:0] o_VECTOR_KEY,
  output logic                      o_BIT_VALID,
  input  logic                      i_BIT_READY,
  output logic                      o_BIT_PRESSED
);

  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);

  logic [KEY_ROWS-1:0]  rows_sync;

  keypad_state_e        state_q,    state_d;
  logic [COL_IDX_W-1:0] idx_q,      idx_d;
  logic [SETTLE_W-1:0]  settle_q,   settle_d;
  logic [DEB_W-1:0]     deb_q,      deb_d;
  logic [KEY_ROWS-1:0]  cap_rows_q, cap_rows_d;
  key_code_t            key_q,      key_d;
  logic                 valid_q,    valid_d;
  logic                 pressed_q,  pressed_d;
  logic [KEY_COLS-1:0]  col_q,      col_d;

  row_synchronizer #(
    .WIDTH (KEY_ROWS)
  ) u_row_sync (
    .clk_i   (i_CLOCK_POS),
    .rst_i   (i_RESET_POS),
    .async_i (i_VECTOR_ROW),
    .sync_o  (rows_sync)
  );

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    settle_d   = settle_q;
    deb_d      = deb_q;
    cap_rows_d = cap_rows_q;
    key_d      = key_q;
    valid_d    = valid_q;
    pressed_d  = pressed_q;

    case (state_q)
      SCAN: begin
        if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
          settle_d = '0;
          if (rows_sync != '1) begin
            cap_rows_d = rows_sync;
            key_d.row  = lowest_low_row(rows_sync);
            key_d.col  = idx_q;
            deb_d      = '0;
            state_d    = DEBOUNCE;
          end else begin
            idx_d = idx_q + COL_IDX_W'(1);
          end
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end

      DEBOUNCE: begin
        if (rows_sync != cap_rows_q) begin
          deb_d    = '0;
          settle_d = '0;
          state_d  = SCAN;
        end else if (deb_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_d     = '0;
          valid_d   = 1'b1;
          pressed_d = 1'b1;
          state_d   = PRESENT;
        end else begin
          deb_d = deb_q + DEB_W'(1);
        end
      end

      PRESENT: begin
        // A release here is ignored; RELEASE waits for the rows to go quiet.
        if (i_BIT_READY) begin
          valid_d = 1'b0;
          deb_d   = '0;
          state_d = RELEASE;
        end
      end

      RELEASE: begin
        if (rows_sync != '1) begin
          deb_d = '0;
        end else if (deb_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_d     = '0;
          settle_d  = '0;
          pressed_d = 1'b0;
          idx_d     = idx_q + COL_IDX_W'(1);
          state_d   = SCAN;
        end else begin
          deb_d = deb_q + DEB_W'(1);
        end
      end

      default: state_d = SCAN;
    endcase

    col_d = ~(KEY_COLS'(1) << idx_d);
  end

  // State and output registers.
  always_ff @(posedge i_CLOCK_POS) begin
    if (i_RESET_POS) begin
      state_q    <= SCAN;
      idx_q      <= '0;
      settle_q   <= '0;
      deb_q      <= '0;
      cap_rows_q <= '1;
      key_q      <= '0;
      valid_q    <= 1'b0;
      pressed_q  <= 1'b0;
      col_q      <= ~KEY_COLS'(1);
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      settle_q   <= settle_d;
      deb_q      <= deb_d;
      cap_rows_q <= cap_rows_d;
      key_q      <= key_d;
      valid_q    <= valid_d;
      pressed_q  <= pressed_d;
      col_q      <= col_d;
    end
  end

  assign o_VECTOR_COLUMN = col_q;
  assign o_VECTOR_KEY    = key_q;
  assign o_BIT_VALID     = valid_q;
  assign o_BIT_PRESSED   = pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives the rows from the
// column strobes, expected codes are queued at press time and popped on handshake.
module tb_keypad_scanner;

  localparam int unsigned SETTLE = 4;
  localparam int unsigned DEB    = 8;
  localparam int          LAT_MAX = 4 * SETTLE + DEB + 3;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       ready = 1'b0;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key;
  logic       valid;
  logic       pressed;

  // held[r*4+c] = 1 means the switch at row r, column c is closed
  logic [15:0] held = '0;

  int checks   = 0;
  int errors   = 0;
  int hs_count = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  keypad_scanner #(
    .SETTLE_CYCLES   (SETTLE),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .i_CLOCK_POS     (clk),
    .i_RESET_POS     (rst),
    .i_VECTOR_ROW    (rows),
    .o_VECTOR_COLUMN (cols),
    .o_VECTOR_KEY    (key),
    .o_BIT_VALID     (valid),
    .i_BIT_READY     (ready),
    .o_BIT_PRESSED   (pressed)
  );

  // Passive matrix: a closed switch pulls its row low while its column is driven.
  always_comb begin
    rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  // Reference: the code is the lowest closed row in the pressed column.
  function automatic logic [3:0] model_key(input logic [15:0] h, input int col);
    model_key = 4'h0;
    for (int r = 3; r >= 0; r--)
      if (h[r*4+col]) model_key = 4'(r * 4 + col);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!valid && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (!valid) begin
      errors++;
      $display("FAIL valid_timeout: got no valid within %0d cycles", budget);
    end
  endtask

  task automatic wait_pressed_low(input int budget);
    int n;
    n = 0;
    while (pressed && n < budget) begin
      tick(1);
      n++;
    end
    check("pressed_release", 32'(pressed), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_col"},     32'(cols),    32'hE);
    check({tag, "_valid"},   32'(valid),   32'd0);
    check({tag, "_key"},     32'(key),     32'h0);
    check({tag, "_pressed"}, 32'(pressed), 32'd0);
  endtask

  // Monitor: pops on handshake and checks that an unaccepted code is held steady.
  logic       prev_valid = 1'b0;
  logic       prev_hs    = 1'b0;
  logic       prev_rst   = 1'b1;
  logic [3:0] prev_key   = 4'h0;

  always @(negedge clk) begin
    logic hs;
    hs = valid && ready && !rst;
    if (prev_valid && !prev_hs && !prev_rst) begin
      check("valid_hold", 32'(valid), 32'd1);
      check("key_hold", 32'(key), 32'(prev_key));
    end
    if (hs) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_code: got %0h expected none", key);
      end else begin
        check("key_code", 32'(key), 32'(exp_q.pop_front()));
      end
    end
    prev_valid = valid;
    prev_hs    = hs;
    prev_rst   = rst;
    prev_key   = key;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int lat;
    int hs0;
    int r;
    int c;
    logic seen;
    logic [3:0] e;

    rst = 1'b1;
    tick(3);
    check_reset_values("reset");
    rst = 1'b0;

    // Idle sweep: SETTLE cycles per column, wrapping.
    for (int k = 0; k < 32; k++) begin
      e = ~(4'b0001 << ((k / 4) % 4));
      check("idle_col", 32'(cols), 32'(e));
      check("idle_valid", 32'(valid), 32'd0);
      tick(1);
    end

    // Clean press row 2 / column 1 with ready held high.
    ready = 1'b1;
    hs0 = hs_count;
    held[2*4+1] = 1'b1;
    exp_q.push_back(model_key(held, 1));
    wait_valid(40, lat);
    check("press_latency_ok", 32'(lat <= LAT_MAX), 32'd1);
    check("pressed_at_valid", 32'(pressed), 32'd1);
    tick(1);
    check("valid_one_cycle", 32'(valid), 32'd0);
    tick(3);
    held = '0;
    tick(8);
    check("pressed_during_release", 32'(pressed), 32'd1);
    tick(4);
    check("pressed_after_release", 32'(pressed), 32'd0);
    check("clean_one_code", 32'(hs_count - hs0), 32'd1);

    // Same key with toggling bounce before it settles.
    tick(10);
    hs0 = hs_count;
    exp_q.push_back(4'h9);
    for (int i = 0; i < 5; i++) begin
      held[2*4+1] = ~held[2*4+1];
      n = int'($urandom_range(1, 3));
      for (int j = 0; j < n; j++) begin
        check("bounce_no_valid", 32'(valid), 32'd0);
        tick(1);
      end
    end
    wait_valid(40, lat);
    tick(2);
    held = '0;
    wait_pressed_low(30);
    check("bounce_one_code", 32'(hs_count - hs0), 32'd1);

    // Key 3 with a stalled consumer; key released while the code waits.
    ready = 1'b0;
    tick(7);
    held[0*4+3] = 1'b1;
    exp_q.push_back(model_key(held, 3));
    wait_valid(40, lat);
    for (int i = 0; i < 50; i++) begin
      if (i == 20) held = '0;
      check("stall_valid_key", {27'd0, valid, key}, {27'd0, 1'b1, 4'h3});
      tick(1);
    end
    ready = 1'b1;
    tick(1);
    check("stall_accepted", 32'(valid), 32'd0);
    wait_pressed_low(30);
    check("scan_resume_col0", 32'(cols), 32'hE);
    tick(SETTLE);
    check("scan_resume_col1", 32'(cols), 32'hD);

    // Two rows closed in column 0: the lower row index wins.
    held[1*4+0] = 1'b1;
    held[3*4+0] = 1'b1;
    exp_q.push_back(model_key(held, 0));
    wait_valid(40, lat);
    tick(1);
    held = '0;
    wait_pressed_low(30);

    // Randomized single presses with random consumer delay.
    for (int i = 0; i < 8; i++) begin
      r = int'($urandom_range(0, 3));
      c = int'($urandom_range(0, 3));
      ready = 1'b0;
      tick(int'($urandom_range(0, 12)));
      held[r*4+c] = 1'b1;
      exp_q.push_back(model_key(held, c));
      wait_valid(40, lat);
      check("rand_latency_ok", 32'(lat <= LAT_MAX), 32'd1);
      tick(int'($urandom_range(0, 4)));
      ready = 1'b1;
      tick(1);
      check("rand_valid_drop", 32'(valid), 32'd0);
      held = '0;
      wait_pressed_low(30);
    end

    // Reset during DEBOUNCE: measure press latency from reset, then reset 3 cycles early.
    ready = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    held[1*4+2] = 1'b1;
    exp_q.push_back(model_key(held, 2));
    wait_valid(40, lat);
    tick(1);
    held = '0;
    wait_pressed_low(30);

    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    held[1*4+2] = 1'b1;
    tick(lat - 3);
    rst = 1'b1;
    held = '0;
    tick(1);
    check_reset_values("rst_debounce");
    rst = 1'b0;
    hs0 = hs_count;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen |= valid;
      tick(1);
    end
    check("rst_debounce_no_code", {31'd0, seen}, 32'd0);
    check("rst_debounce_no_hs", 32'(hs_count - hs0), 32'd0);

    // Reset while a code is pending in PRESENT.
    ready = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    held[1*4+2] = 1'b1;
    wait_valid(40, lat);
    rst = 1'b1;
    held = '0;
    tick(1);
    check_reset_values("rst_present");
    rst = 1'b0;
    ready = 1'b1;
    hs0 = hs_count;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen |= valid;
      tick(1);
    end
    check("rst_present_no_code", {31'd0, seen}, 32'd0);
    check("rst_present_no_hs", 32'(hs_count - hs0), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
